pattern_serializer: RTL and testbench
=====================================

// Module: pattern_serializer
// PURPOSE
//  Upstream stage of the sequence detector: accepts a WIDTH-bit pattern word over a
//  valid/ready load port and presents it one bit per advance cycle on x, MSB first.
//  Feeds x/x_valid directly into the Mealy detector's serial input.
//  Replaces hand-driven bit streams with a hardware source that supports stalls and back-to-back words.
// PARAMETERS
//  WIDTH     16  bits per pattern word (>=2)
//  MSB_FIRST 1   1: bit WIDTH-1 first; 0: bit 0 first
//  CNT_W     $clog2(WIDTH)  bit-counter width (derived; do not override)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  load_valid  in   1      load_data is offered
//  load_data   in   WIDTH  pattern word
//  load_ready  out  1      word accepted on edge where load_valid&&load_ready
//  adv         in   1      downstream consumes current bit this cycle
//  x           out  1      current serial bit (to detector x)
//  x_valid     out  1      x holds a live bit
//  busy        out  1      word in flight (state SHIFT)
//  done        out  1      one-cycle pulse after last bit of a word consumed
//  loop        in   1      only when SERIALIZER_LOOP_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, shreg=0, bit_cnt=0, x=0, x_valid=0, busy=0, done=0.
//   load_ready reads 1 in IDLE; loads offered during reset are ignored.
//  States: IDLE, SHIFT.
//  IDLE: load_ready=1. On load_valid -> shreg<=load_data, bit_cnt<=0, -> SHIFT.
//   Next cycle x = first bit, x_valid=1 (1-cycle load-to-bit latency).
//  SHIFT: x_valid=1, busy=1. adv=0: hold x, shreg, bit_cnt (stall, no limit).
//   adv=1 and bit_cnt<WIDTH-1: shift, bit_cnt++, next bit on x next cycle.
//   adv=1 and bit_cnt==WIDTH-1 (last): done<=1 for exactly one cycle; load_ready=1 this cycle;
//    if load_valid also high -> new word loaded, stay SHIFT, x_valid stays 1 (no bubble);
//    else -> IDLE, x_valid<=0, x<=0.
//  load_ready = (state==IDLE) || (state==SHIFT && last && adv); combinational, no other path.
//  load_valid in SHIFT when not last+adv: ignored, not buffered; load_data needs stability only on accept.
//  x, x_valid, busy, done registered; x never glitches mid-cycle.
//  Reset asserted mid-word: word discarded, no done pulse, outputs to reset values immediately.
//  bit_cnt saturates logically at WIDTH-1; never wraps past it within one word.
// CONFIGURATION
//  SERIALIZER_LOOP_EN defined: port loop present. On last bit with adv=1, load_valid=0 and
//   loop=1 -> shreg reloaded from stored copy of current word, stay SHIFT, done still pulses.
//   load_valid=1 has priority over loop (new word wins).
//  Not defined: no loop port, no word copy register; last bit always goes to IDLE or new load.
// STRUCTURE
//  Package seq_detect_pkg: state typedef (IDLE/SHIFT), default WIDTH constant 16,
//   shared with the detector and its benches.
//  Sub-module ser_bit_counter (CNT_W counter, clear/inc/last flag) is the one natural split;
//   shift register and FSM stay in this module.
// TESTING
//  1) Reset low 2 cycles, release; load 16'hAAA0 with adv=1 constant -> x = 1010101010100000
//     on cycles 1..16 after accept, x_valid=1 for those 16 cycles, done=1 on cycle 17 only.
//  2) Chain into seq_101010_detector with test 1 -> z matches detector's expected 101010
//     hits (overlap positions), bit-for-bit with a software model.
//  3) Stall: load 16'hF00F, drop adv for 3 cycles after bit 4 -> x holds bit 4 (0) for 4
//     cycles, total 19 x_valid cycles, sequence unchanged.
//  4) Back-to-back: load_valid held with 16'hAAAA then 16'h5555 -> 32 consecutive x_valid
//     cycles, no bubble, done pulses at cycles 17 and 33, load_ready high only on last bits.
//  5) Reset mid-word at bit 7 -> x=0, x_valid=0, busy=0 asynchronously, no done pulse;
//     next load restarts at bit 0.
//  6) SERIALIZER_LOOP_EN, loop=1, word 16'h0015 -> pattern repeats 3 times without load,
//     done pulses every 16 cycles; loop=0 -> IDLE after current word.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the sequence-detector chain (serializer, detector, benches).
package seq_detect_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the pattern serializer; flags the last bit of a word and
// saturates there until cleared.
module ser_bit_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LastIdx);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// Loads a WIDTH-bit pattern over valid/ready and emits it one bit per adv cycle on x.
// Optional SERIALIZER_LOOP_EN adds a loop input that replays the current word.
module pattern_serializer
  import seq_detect_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             adv,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
`ifdef SERIALIZER_LOOP_EN
  ,
  input  logic             loop
`endif
);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_inc, cnt_last;
`ifdef SERIALIZER_LOOP_EN
  logic [WIDTH-1:0] word_q, word_d;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  ser_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    x_d        = x_q;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    load_ready = 1'b0;
`ifdef SERIALIZER_LOOP_EN
    word_d     = word_q;
`endif
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_d = SHIFT;
          shreg_d = load_data;
          x_d     = first_bit(load_data);
          cnt_clr = 1'b1;
`ifdef SERIALIZER_LOOP_EN
          word_d  = load_data;
`endif
        end
      end
      SHIFT: begin
        if (adv && !cnt_last) begin
          shreg_d = shift_word(shreg_q);
          x_d     = first_bit(shift_word(shreg_q));
          cnt_inc = 1'b1;
        end else if (adv) begin
          // Last bit consumed: a waiting word follows with no bubble.
          done_d     = 1'b1;
          load_ready = 1'b1;
          cnt_clr    = 1'b1;
          if (load_valid) begin
            shreg_d = load_data;
            x_d     = first_bit(load_data);
`ifdef SERIALIZER_LOOP_EN
            word_d  = load_data;
          end else if (loop) begin
            shreg_d = word_q;
            x_d     = first_bit(word_q);
`endif
          end else begin
            state_d = IDLE;
            x_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIALIZER_LOOP_EN
  // NOTE: the word copy is pure data, so it skips the reset and stays out of the reset tree.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end
`endif

  assign x       = x_q;
  assign x_valid = (state_q == SHIFT);
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: a bit-queue reference model predicts every
// output each cycle; directed spec scenarios followed by randomized traffic.
module tb_pattern_serializer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready;
  logic             adv = 1'b0;
  logic             x, x_valid, busy, done;
  logic             loop_drv = 1'b0;
  logic             loop_i;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;
  int dcnt     = 0;

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .adv       (adv),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done)
`ifdef SERIALIZER_LOOP_EN
    ,
    .loop      (loop_drv)
`endif
  );

`ifdef SERIALIZER_LOOP_EN
  assign loop_i = loop_drv;
`else
  assign loop_i = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bits still owed for the current word, MSB first.
  logic             exp_q[$];
  logic [WIDTH-1:0] saved_word;
  logic             exp_done = 1'b0;
  bit               live, consume, last_bit, model_ready;

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
    saved_word = w;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_done = 1'b0;
      check("rst_x", x, 0);
      check("rst_x_valid", x_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end else begin
      live        = (exp_q.size() != 0);
      consume     = live && adv;
      last_bit    = consume && (exp_q.size() == 1);
      model_ready = !live || last_bit;
      check("load_ready", load_ready, model_ready);
      check("x_valid", x_valid, live);
      check("busy", busy, live);
      check("done", done, exp_done);
      check("x", x, live ? exp_q[0] : 1'b0);
      if (x_valid) vcnt++;
      if (done) dcnt++;
      if (consume) void'(exp_q.pop_front());
      if (model_ready && load_valid) push_word(load_data);
      else if (last_bit && loop_i) push_word(saved_word);
      exp_done = last_bit;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy; i++) cyc(1);
    check(tag, busy, 0);
    cyc(2);
  endtask

  int v0, d0;

  initial begin
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // Test 1: single word, adv held high.
    v0 = vcnt; d0 = dcnt;
    load_valid = 1'b1; load_data = 16'hAAA0; adv = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    wait_idle(40, "t1_idle");
    check("t1_valid_cycles", vcnt - v0, 16);
    check("t1_done_pulses", dcnt - d0, 1);

    // Test 3: stall on bit index 4 for three cycles.
    v0 = vcnt; d0 = dcnt;
    load_valid = 1'b1; load_data = 16'hF00F; adv = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    cyc(4);
    adv = 1'b0;
    cyc(3);
    adv = 1'b1;
    wait_idle(40, "t3_idle");
    check("t3_valid_cycles", vcnt - v0, 19);
    check("t3_done_pulses", dcnt - d0, 1);

    // Test 4: back-to-back words with load_valid held.
    v0 = vcnt; d0 = dcnt;
    load_valid = 1'b1; load_data = 16'hAAAA; adv = 1'b1;
    cyc(1);
    load_data = 16'h5555;
    for (int i = 0; i < 40 && !load_ready; i++) cyc(1);
    cyc(1);
    load_valid = 1'b0;
    wait_idle(40, "t4_idle");
    check("t4_valid_cycles", vcnt - v0, 32);
    check("t4_done_pulses", dcnt - d0, 2);

    // Test 5: async reset mid-word, loads offered during reset are ignored.
    d0 = dcnt;
    load_valid = 1'b1; load_data = 16'h1234; adv = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    cyc(7);
    #2 reset = 1'b0;
    load_valid = 1'b1; load_data = 16'hFFFF;
    #1;
    check("t5_async_x", x, 0);
    check("t5_async_x_valid", x_valid, 0);
    check("t5_async_busy", busy, 0);
    cyc(2);
    load_valid = 1'b0;
    reset = 1'b1;
    cyc(1);
    check("t5_no_done", dcnt - d0, 0);
    v0 = vcnt;
    load_valid = 1'b1; load_data = 16'h8001;
    cyc(1);
    load_valid = 1'b0;
    wait_idle(40, "t5_idle");
    check("t5_restart_cycles", vcnt - v0, 16);

`ifdef SERIALIZER_LOOP_EN
    // Test 6: loop replays the word three times, then drains to IDLE.
    v0 = vcnt; d0 = dcnt;
    load_valid = 1'b1; load_data = 16'h0015; adv = 1'b1; loop_drv = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    cyc(48);
    loop_drv = 1'b0;
    wait_idle(40, "t6_idle");
    check("t6_valid_cycles", vcnt - v0, 64);
    check("t6_done_pulses", dcnt - d0, 4);
`endif

    // Randomized traffic: sporadic loads, random stalls, optional loop.
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 2) == 0);
      load_data  = WIDTH'($urandom);
      adv        = ($urandom_range(0, 3) != 0);
      loop_drv   = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    load_valid = 1'b0; adv = 1'b1; loop_drv = 1'b0;
    wait_idle(200, "rand_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
